// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between a UART receiver and its consumer.
// It has a registered read port and a sticky flag that records dropped bytes.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_rx_hs,
    input  logic              i_rd_en,
    input  logic              i_clr_ovf,
    output logic [7:0]        o_rd_data,
    output logic              o_rd_valid,
    output logic              o_empty,
    output logic              o_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              drop_s;

    // Accept/drop decisions; a read frees the slot a same-cycle write needs when full.
    always_comb begin
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        drop_s   = 1'b0;
        if (i_rd_en && !empty_q) begin
            rd_acc_s = 1'b1;
        end else begin
            rd_acc_s = 1'b0;
        end
        if (i_rx_hs && (!full_q || rd_acc_s)) begin
            wr_acc_s = 1'b1;
        end else begin
            wr_acc_s = 1'b0;
        end
        if (i_rx_hs && !wr_acc_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // Next-state for pointers, occupancy, flags and the read port.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
        end else begin
            rd_ptr_d   = rd_ptr_q;
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        empty_d = (count_d == {(ADDR_W + 1){1'b0}});
        full_d  = (count_d == FULL_CNT);
    end

    // Control and output registers; reset clears them immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            count_q    <= {(ADDR_W + 1){1'b0}};
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage array; its contents survive reset and are discarded by the pointer clear.
    always_ff @(posedge i_clk) begin
        if (wr_acc_s) begin
            mem[wr_ptr_q] <= i_rx_byte;
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_empty    = empty_q;
    assign o_full     = full_q;
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo.
// A reference occupancy model drives a byte scoreboard whose entries are popped when o_rd_valid pulses.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              i_clk;
    logic              i_rst;
    logic [7:0]        i_rx_byte;
    logic              i_rx_hs;
    logic              i_rd_en;
    logic              i_clr_ovf;
    logic [7:0]        o_rd_data;
    logic              o_rd_valid;
    logic              o_empty;
    logic              o_full;
    logic [ADDR_W:0]   o_count;
    logic              o_overflow;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_byte  (i_rx_byte),
        .i_rx_hs    (i_rx_hs),
        .i_rd_en    (i_rd_en),
        .i_clr_ovf  (i_clr_ovf),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int         total_cnt = 0;
    int         pass_cnt  = 0;
    logic [7:0] sb [$];
    int         m_count   = 0;
    logic       m_ovf     = 1'b0;
    logic [7:0] m_last    = 8'h00;
    logic [7:0] exp_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_status();
        chk("count", 32'(o_count), 32'(m_count));
        chk("empty", 32'(o_empty), 32'(m_count == 0));
        chk("full", 32'(o_full), 32'(m_count == DEPTH));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model, then compare just after the edge.
    task automatic step(input logic hs, input logic [7:0] b, input logic rd, input logic clr);
        bit rd_ok, wr_ok, drop;
        i_rx_hs   = hs;
        i_rx_byte = b;
        i_rd_en   = rd;
        i_clr_ovf = clr;
        rd_ok = rd && (m_count != 0);
        wr_ok = hs && ((m_count != DEPTH) || rd_ok);
        drop  = hs && !wr_ok;
        @(posedge i_clk);
        #1;
        if (wr_ok) sb.push_back(b);
        if (wr_ok && !rd_ok) m_count++;
        if (rd_ok && !wr_ok) m_count--;
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        chk("rd_valid", 32'(o_rd_valid), 32'(rd_ok));
        if (o_rd_valid) begin
            if (sb.size() == 0) begin
                chk("rd_unexpected", 32'(o_rd_data), 32'hFFFF_FFFF);
            end else begin
                exp_b  = sb.pop_front();
                m_last = exp_b;
                chk("rd_data", 32'(o_rd_data), 32'(exp_b));
            end
        end else begin
            chk("rd_data_hold", 32'(o_rd_data), 32'(m_last));
        end
        check_status();
        i_rx_hs   = 1'b0;
        i_rd_en   = 1'b0;
        i_clr_ovf = 1'b0;
    endtask

    initial begin
        i_rst     = 1'b1;
        i_rx_byte = 8'h00;
        i_rx_hs   = 1'b0;
        i_rd_en   = 1'b0;
        i_clr_ovf = 1'b0;
        #1;
        chk("reset_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("reset_rd_data", 32'(o_rd_data), 32'h00);
        check_status();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Single byte round trip with one-cycle read latency.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to DEPTH, drop one byte, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Clear overflow, refill, and exercise the full-FIFO read+write pass-through.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b1, 8'hFE, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // A read request on an empty FIFO is ignored even with a same-cycle write.
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Forty interleaved writes keep occupancy within 5..12 and wrap the pointers.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h40 + i), (m_count >= 12) || ((m_count >= 5) && (i % 3 != 0)), 1'b0);
        end
        while (m_count > 0) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges, with a read pulse in progress.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        #3;
        i_rst = 1'b1;
        #1;
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_last  = 8'h00;
        chk("async_rst_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("async_rst_rd_data", 32'(o_rd_data), 32'h00);
        check_status();
        @(posedge i_clk);
        #1;
        chk("rst_hold_rd_valid", 32'(o_rd_valid), 32'd0);
        i_rst = 1'b0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, 2..256.
REQ-002 Parameter ADDR_W, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_rx_byte  input  8  received byte from the UART receiver bus.
REQ-006 i_rx_hs  input  1  one-cycle strobe; i_rx_byte is valid in that cycle.
REQ-007 i_rd_en  input  1  read request from the consumer, sampled each cycle.
REQ-008 i_clr_ovf  input  1  clears the sticky overflow flag.
REQ-009 o_rd_data  output  8  registered read data.
REQ-010 o_rd_valid  output  1  one-cycle pulse; o_rd_data is valid in that cycle.
REQ-011 o_empty  output  1  high when count = 0.
REQ-012 o_full  output  1  high when count = DEPTH.
REQ-013 o_count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
REQ-014 o_overflow  output  1  sticky; set when a byte is dropped.

Function
REQ-015 Storage: DEPTH x 8 memory, write pointer, read pointer (ADDR_W bits each, modulo-DEPTH wrap) and count register of ADDR_W+1 bits.
REQ-016 Write accepted: i_rx_hs=1 and (o_full=0, or a read is accepted in the same cycle); stores i_rx_byte at wr_ptr; wr_ptr +1 mod DEPTH.
REQ-017 Read accepted: i_rd_en=1 and o_empty=0; o_rd_data <= mem[rd_ptr]; o_rd_valid=1 next cycle; rd_ptr +1 mod DEPTH.
REQ-018 Read latency: exactly one clock from the accepted i_rd_en edge to the o_rd_valid pulse.
REQ-019 i_rd_en while empty: no read, o_rd_valid=0, no pointer change, no error flag, including when a write occurs in the same cycle (the written byte becomes readable next cycle).
REQ-020 Count: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-021 Simultaneous read and write when full: both accepted, count stays DEPTH, o_overflow unchanged.
REQ-022 i_rx_hs while full without an accepted read: byte dropped; memory, pointers and count unchanged; o_overflow <= 1.
REQ-023 o_overflow holds until i_clr_ovf=1 or reset; if i_clr_ovf and a drop occur in the same cycle, set wins (o_overflow=1).
REQ-024 o_empty, o_full and o_count derive from registered count and SHALL reflect every update in the cycle after the edge.
REQ-025 o_rd_data holds its last value when o_rd_valid=0.
REQ-026 Pointer wrap: after DEPTH writes and DEPTH reads, bytes SHALL emerge in write order with no loss or duplication.

Reset
REQ-027 While i_rst=1, immediately and independent of i_clk: pointers=0, count=0, o_empty=1, o_full=0, o_count=0, o_overflow=0, o_rd_valid=0, o_rd_data=8'h00.
REQ-028 Memory contents are not reset; stored bytes are discarded logically by pointer clear.
REQ-029 Reset asserted mid-operation (FIFO partly full, read in flight) SHALL abort the read; no o_rd_valid pulse after i_rst rises.
REQ-030 First accepted write or read is the first rising i_clk edge with i_rst=0.

Verification
REQ-031 Reset, then write 8'hA5, then i_rd_en one cycle -> o_rd_valid pulse exactly one cycle after i_rd_en with o_rd_data=8'hA5, o_empty=1 after.
REQ-032 Write 16 bytes 8'h00..8'h0F -> o_full=1, o_count=16; 17th write 8'hFF -> o_overflow=1, count 16; read all 16 -> 8'h00..8'h0F in order, 8'hFF never appears.
REQ-033 Full FIFO, i_rx_hs and i_rd_en in the same cycle -> oldest byte read, new byte stored, o_count=16, o_overflow=0.
REQ-034 Empty FIFO, i_rd_en with i_rx_hs of 8'h3C -> no o_rd_valid that cycle, o_count=1; next read returns 8'h3C.
REQ-035 40 writes interleaved with reads at count 5..12 -> pointers wrap twice, output sequence equals input sequence.
REQ-036 Assert i_rst asynchronously with count=7 between clock edges -> o_count=0, o_empty=1, o_overflow=0 before the next edge; no o_rd_valid pulse follows.
